core101_mem_arbiter: RTL
========================

// Module: core101_mem_arbiter
// PURPOSE
//  N-master, single-slave memory arbiter for Core101 valid/ready memory ports.
//  Lets the instruction port, data port and future masters share one memory.
//  Each request is granted in round-robin order and forwarded with registered
//  address, data and write signals. The response returns to the granted master.
//  Sits between Core101 (and any DMA masters) and a unified INS/DATA memory.
// PARAMETERS
//  XLEN            32   address/data width
//  N_MASTERS       2    number of requesting masters (>=2)
//  TIMEOUT_CYCLES  255  slave wait limit; used only with CORE101_ARB_TIMEOUT_EN
// PORTS
//  clock_in      in   1            single clock, rising edge
//  reset_in      in   1            asynchronous reset, active-high
//  m_valid_in    in   N_MASTERS    per-master request valid
//  m_write_in    in   N_MASTERS    per-master write(1)/read(0)
//  m_addr_in     in   N_MASTERS*XLEN  packed addresses, master i at [i*XLEN +: XLEN]
//  m_data_in     in   N_MASTERS*XLEN  packed write data, same packing
//  m_ready_out   out  N_MASTERS    one-hot response pulse to the granted master
//  m_data_out    out  XLEN         shared read data; valid while m_ready_out!=0
//  m_err_out     out  1            response error flag; valid with m_ready_out
//  s_valid_out   out  1            slave request valid
//  s_write_out   out  1            slave write strobe
//  s_addr_out    out  XLEN         slave address
//  s_data_out    out  XLEN         slave write data
//  s_ready_in    in   1            slave completion
//  s_data_in     in   XLEN         slave read data, sampled when s_ready_in=1
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0; state=IDLE; last_grant=N_MASTERS-1,
//    so master 0 wins the first arbitration; timeout counter=0.
//  - FSM IDLE -> REQ -> RESP -> IDLE. All outputs are registered.
//  - IDLE: if any m_valid_in is set, pick the first set bit searching upward
//    from last_grant+1 (mod N_MASTERS). Latch grant, addr, data and write.
//    Set s_valid_out=1 and go to REQ. With no request, stay in IDLE.
//  - REQ: hold s_* stable and ignore master inputs. When s_ready_in=1:
//    register m_data_out=s_data_in for a read (0 for a write) and set
//    m_ready_out[grant]=1, m_err_out=0. Then clear s_valid_out, set
//    last_grant=grant and go to RESP. s_valid_out falls on the same edge.
//  - RESP: m_ready_out is high for exactly this cycle, then 0. Go to IDLE.
//    Masters must drop or replace m_valid_in on the edge after they see ready.
//    RESP prevents re-granting a stale request.
//  - Latency: s_valid_out rises 1 cycle after m_valid_in. m_ready_out rises
//    1 cycle after s_ready_in. The minimum round trip is 3 cycles.
//  - Back-to-back requests: IDLE re-arbitrates on the cycle after RESP. A master
//    that keeps requesting cannot win twice while another master is pending.
//  - Masters must hold m_valid_in, addr, data and write until their ready pulse.
//    Dropping a request early is a protocol violation; a latched request still completes.
//  - Simultaneous requests: only one master is granted; the others wait in order.
//  - s_ready_in outside REQ is ignored.
// CONFIGURATION
//  `CORE101_ARB_TIMEOUT_EN defined: a counter runs in REQ and clears on entry.
//    It counts TIMEOUT_CYCLES cycles without s_ready_in, then aborts the request.
//    On abort: s_valid_out=0, m_ready_out[grant] pulses (RESP), m_err_out=1 and
//    m_data_out=0. If s_ready_in arrives on the terminal cycle, it wins (no error).
//  Not defined: no counter. REQ waits indefinitely. m_err_out is tied 0.
// STRUCTURE
//  core101_arb_pkg: state encodings IDLE/REQ/RESP, clog2 helper, GRANT_W.
//  Sub-module core101_rr_pick: combinational round-robin picker.
//    Inputs: request vector and last_grant. Outputs: grant index and any_req.
//    The top holds the FSM, latches and the optional timeout counter.
// TESTING
//  1 N=2; m0 reads 0x40; s_ready_in after 3 REQ cycles with s_data_in=0xDEADBEEF
//    -> s_addr_out=0x40, s_write_out=0; m_ready_out=2'b01 for 1 cycle;
//    m_data_out=0xDEADBEEF; m_err_out=0.
//  2 Both masters request continuously; slave answers immediately
//    -> grants m0,m1,m0,m1; each round trip is 3 cycles.
//  3 m1 writes 0x12345678 to 0x100 -> s_write_out=1, s_addr_out=0x100,
//    s_data_out=0x12345678; m_ready_out=2'b10; m_data_out=0.
//  4 reset_in asserted mid-REQ -> all outputs 0 at once; after release,
//    both masters request -> m0 is granted first.
//  5 Macro on, TIMEOUT_CYCLES=4, s_ready_in held 0 -> m_ready_out and m_err_out=1
//    pulse after 4 REQ cycles. Macro off -> s_valid_out stays high for 100 cycles.
//  6 s_ready_in=1 with m_valid_in 0 while IDLE -> no state change, outputs stay 0.

Source files
------------

// File: rtl/core101_arb_pkg.sv
// Shared types and helpers for the Core101 memory arbiter.
// Holds FSM state encodings, an index-width helper and GRANT_W.
package core101_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width, never less than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  localparam int DEF_N_MASTERS = 2;
  localparam int GRANT_W = idx_w(DEF_N_MASTERS);

endpackage

// File: rtl/core101_rr_pick.sv
// Combinational round-robin picker: first set request bit at or
// above last_i+1 (mod N). Ports: req_i, last_i -> grant_o, any_o.
module core101_rr_pick
  import core101_arb_pkg::*;
#(
  parameter int N  = DEF_N_MASTERS,
  parameter int GW = GRANT_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] grant_o,
  output logic          any_o
);

  logic [GW-1:0] idx;

  // Walk from farthest to nearest candidate; the nearest hit
  // is assigned last and therefore wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(last_i) + k) % N);
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core101_mem_arbiter.sv
// N-master, single-slave round-robin arbiter for Core101 memory ports.
// Ports: clock_in/reset_in; m_* master side (packed per master),
// s_* slave side; all outputs registered. IDLE -> REQ -> RESP.
// Optional slave timeout: define CORE101_ARB_TIMEOUT_EN.
module core101_mem_arbiter
  import core101_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic [N_MASTERS-1:0]      m_valid_in,
  input  logic [N_MASTERS-1:0]      m_write_in,
  input  logic [N_MASTERS*XLEN-1:0] m_addr_in,
  input  logic [N_MASTERS*XLEN-1:0] m_data_in,
  output logic [N_MASTERS-1:0]      m_ready_out,
  output logic [XLEN-1:0]           m_data_out,
  output logic                      m_err_out,
  output logic                      s_valid_out,
  output logic                      s_write_out,
  output logic [XLEN-1:0]           s_addr_out,
  output logic [XLEN-1:0]           s_data_out,
  input  logic                      s_ready_in,
  input  logic [XLEN-1:0]           s_data_in
);

  localparam int GW = idx_w(N_MASTERS);
  localparam logic [GW-1:0] LAST_RST = GW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ONE = 1;

  arb_state_e           state_q;
  logic [GW-1:0]        last_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        grant_d;
  logic                 any_d;
  logic                 s_valid_q;
  logic                 s_write_q;
  logic [XLEN-1:0]      s_addr_q;
  logic [XLEN-1:0]      s_data_q;
  logic [N_MASTERS-1:0] m_ready_q;
  logic [XLEN-1:0]      m_data_q;
  logic                 m_err_q;

`ifdef CORE101_ARB_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

  core101_rr_pick #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_pick (
    .req_i   (m_valid_in),
    .last_i  (last_q),
    .grant_o (grant_d),
    .any_o   (any_d)
  );

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      s_valid_q <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q  <= '0;
      s_data_q  <= '0;
      m_ready_q <= '0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
`ifdef CORE101_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_d) begin
            grant_q   <= grant_d;
            s_addr_q  <= m_addr_in[grant_d*XLEN +: XLEN];
            s_data_q  <= m_data_in[grant_d*XLEN +: XLEN];
            s_write_q <= m_write_in[grant_d];
            s_valid_q <= 1'b1;
            state_q   <= S_REQ;
`ifdef CORE101_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
          end
        end
        S_REQ: begin
          // Slave completion beats the timeout on the terminal cycle.
          if (s_ready_in) begin
            m_data_q  <= s_write_q ? '0 : s_data_in;
            m_ready_q <= ONE << grant_q;
            m_err_q   <= 1'b0;
            s_valid_q <= 1'b0;
            last_q    <= grant_q;
            state_q   <= S_RESP;
          end
`ifdef CORE101_ARB_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            m_data_q  <= '0;
            m_ready_q <= ONE << grant_q;
            m_err_q   <= 1'b1;
            s_valid_q <= 1'b0;
            last_q    <= grant_q;
            state_q   <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          m_ready_q <= '0;
          m_data_q  <= '0;
          m_err_q   <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_ready_out = m_ready_q;
  assign m_data_out  = m_data_q;
  assign m_err_out   = m_err_q;
  assign s_valid_out = s_valid_q;
  assign s_write_out = s_write_q;
  assign s_addr_out  = s_addr_q;
  assign s_data_out  = s_data_q;

endmodule
